// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_ctrl_pkg;

  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;
  localparam logic [4:0] REG_X0  = 5'd0;

  typedef struct packed {
    logic [3:0]  we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        unsign;
  } wb_req_t;

  // x0 is hardwired, so a write aimed at it must never reach the register file.
  function automatic logic [3:0] gated_we(input wb_req_t req);
    if (req.rd == REG_X0) begin
      return 4'b0000;
    end else begin
      return req.we;
    end
  endfunction

  function automatic logic legal_mask(input logic [3:0] we);
    return (we == WE_BYTE) || (we == WE_HALF) || (we == WE_WORD);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_chk.sv
// Protocol checks on the decode/load-unit side of the write-back arbiter.
module rf_wb_arbiter_chk (
  input logic        clk,
  input logic        reset,
  input logic        ld_issue,
  input logic [4:0]  ld_issue_rd,
  input logic        hazard_stall,
  input logic [31:0] busy_mask,
  input logic        ld_valid,
  input logic        ld_ready,
  input logic [3:0]  ld_we,
  input logic        fifo_push,
  input logic        fifo_full
);
  import rf_ctrl_pkg::*;

  issue_while_stalled: assert property (@(posedge clk) disable iff (reset)
    !(ld_issue && hazard_stall))
    else $error("load issued while decode was stalled");

  issue_to_busy_rd: assert property (@(posedge clk) disable iff (reset)
    !(ld_issue && (ld_issue_rd != REG_X0) && busy_mask[ld_issue_rd]))
    else $error("load issued to a destination already awaiting a load");

  return_mask_legal: assert property (@(posedge clk) disable iff (reset)
    !(ld_valid && ld_ready) || legal_mask(ld_we))
    else $error("load return with illegal byte mask");

  push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full))
    else $error("load FIFO pushed while full");

endmodule

// File: rtl/rf_wb_arbiter_fifo.sv
// Synchronous FIFO of write-back requests buffering load returns.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic           do_push_s;
  logic           do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, power-of-two pointers wrap naturally, occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU results and load returns.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int LDQ_DEPTH = 2,
  parameter int MAX_LD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rd_we,
  input  logic        dec_is_load,
  output logic        hazard_stall,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_wdata,
  input  logic [3:0]  ld_we,
  input  logic        ld_unsign,
  output logic [3:0]  wb_we,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_rd,
  output logic        wb_unsign,
  output logic [31:0] busy_mask
);

  localparam int CNT_W = $clog2(MAX_LD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LD);

  wb_req_t          ld_req_s;
  wb_req_t          alu_req_s;
  wb_req_t          fifo_head_s;
  wb_req_t          grant_req_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             any_grant_s;
  logic             ld_grant_s;
  logic [31:0]      busy_set_s;
  logic [31:0]      busy_clr_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;
  logic             rd_busy_s;
  logic [31:0]      busy_r;
  logic [CNT_W-1:0] ld_cnt_r;

  assign ld_req_s  = '{we: ld_we, rd: ld_rd, wdata: ld_wdata, unsign: ld_unsign};
  assign alu_req_s = '{we: WE_WORD, rd: alu_rd, wdata: alu_wdata, unsign: 1'b0};
  assign ld_ready  = !reset && !fifo_full_s;
  assign accept_s  = ld_valid && ld_ready;
  assign busy_mask = busy_r;

  // Fixed-priority grant: ALU, then FIFO head, then same-cycle bypass of a fresh return.
  always_comb begin
    grant_req_s = alu_req_s;
    any_grant_s = 1'b0;
    ld_grant_s  = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (alu_valid) begin
      any_grant_s = 1'b1;
      push_s      = accept_s;
    end else if (!fifo_empty_s) begin
      grant_req_s = fifo_head_s;
      any_grant_s = 1'b1;
      ld_grant_s  = 1'b1;
      pop_s       = 1'b1;
      push_s      = accept_s;
    end else if (accept_s) begin
      grant_req_s = ld_req_s;
      any_grant_s = 1'b1;
      ld_grant_s  = 1'b1;
    end else begin
      grant_req_s = alu_req_s;
    end
  end

  wb_fifo #(
    .DEPTH (LDQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (ld_req_s),
    .dout  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Registered write port; wb_* other than the enable hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we     <= 4'b0000;
      wb_wdata  <= 32'h0000_0000;
      wb_rd     <= 5'd0;
      wb_unsign <= 1'b0;
    end else if (any_grant_s) begin
      wb_we     <= gated_we(grant_req_s);
      wb_wdata  <= grant_req_s.wdata;
      wb_rd     <= grant_req_s.rd;
      wb_unsign <= grant_req_s.unsign;
    end else begin
      wb_we     <= 4'b0000;
    end
  end

  // Scoreboard set/clear vectors; x0 is never marked.
  always_comb begin
    busy_set_s = 32'h0000_0000;
    busy_clr_s = 32'h0000_0000;
    if (ld_issue && (ld_issue_rd != REG_X0)) begin
      busy_set_s[ld_issue_rd] = 1'b1;
    end else begin
      busy_set_s = 32'h0000_0000;
    end
    if (ld_grant_s) begin
      busy_clr_s[grant_req_s.rd] = 1'b1;
    end else begin
      busy_clr_s = 32'h0000_0000;
    end
  end

  // Set after clear so a same-cycle reissue to the retiring rd keeps it busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 32'h0000_0000;
    end else begin
      busy_r <= (busy_r & ~busy_clr_s) | busy_set_s;
    end
  end

  // Outstanding-load credit counter, saturating at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({ld_issue, ld_grant_s})
        2'b10: begin
          if (ld_cnt_r != CNT_MAX) begin
            ld_cnt_r <= ld_cnt_r + 1'b1;
          end else begin
            ld_cnt_r <= ld_cnt_r;
          end
        end
        2'b01: begin
          if (ld_cnt_r != {CNT_W{1'b0}}) begin
            ld_cnt_r <= ld_cnt_r - 1'b1;
          end else begin
            ld_cnt_r <= ld_cnt_r;
          end
        end
        default: ld_cnt_r <= ld_cnt_r;
      endcase
    end
  end

  // Decode hazards: RAW on either source, WAW on the destination, or no load credits left.
  always_comb begin
    rs1_busy_s   = (dec_rs1 != REG_X0) && busy_r[dec_rs1];
    rs2_busy_s   = (dec_rs2 != REG_X0) && busy_r[dec_rs2];
    rd_busy_s    = dec_rd_we && (dec_rd != REG_X0) && busy_r[dec_rd];
    hazard_stall = rs1_busy_s || rs2_busy_s || rd_busy_s
                   || (dec_is_load && (ld_cnt_r == CNT_MAX));
  end

  rf_wb_arbiter_chk u_chk (
    .clk          (clk),
    .reset        (reset),
    .ld_issue     (ld_issue),
    .ld_issue_rd  (ld_issue_rd),
    .hazard_stall (hazard_stall),
    .busy_mask    (busy_r),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_we        (ld_we),
    .fifo_push    (push_s),
    .fifo_full    (fifo_full_s)
  );

endmodule
